// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: next-PC select encoding, fetch FSM states
// and the default instruction word shown to decode when nothing valid is held.
package mips_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and the
// instruction memory (slave): one request/address out, ready/data back.
interface fetch_ctrl_if;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_rdata_i
   );

endinterface

// File: rtl/fetch_perf_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping;
// used by fetch_ctrl when FETCH_CTRL_PERF_EN is defined.
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/WAIT/HOLD sequencing, redirects with stale-word
// kill, decode-side stall. Define FETCH_CTRL_PERF_EN to add saturating perf counters.
module fetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   pcsrc_i,
   input  logic [31:0]  br_dest_i,
   input  logic [31:0]  jmp_dest_i,
   input  logic         stall_i,
   fetch_ctrl_if.master imem,
   output logic [31:0]  ir_o,
   output logic [31:0]  npc_o,
   output logic         ir_valid_o
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]  perf_fetch_o,
   output logic [31:0]  perf_stall_o,
   output logic [31:0]  perf_redirect_o
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  npc_q, npc_d;
   logic         vld_q, vld_d;
   logic         kill_q, kill_d;

   logic         redirect;
   logic         accept;
   logic [31:0]  dest;

   assign redirect = (state_q != ST_BOOT) &&
                     ((pcsrc_i == PCSRC_BR) || (pcsrc_i == PCSRC_JMP));
   assign dest     = (pcsrc_i == PCSRC_BR) ? br_dest_i : jmp_dest_i;
   assign accept   = (state_q == ST_WAIT) && imem.imem_ready_i && !kill_q && !redirect;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      npc_d   = npc_q;
      vld_d   = vld_q;
      kill_d  = kill_q;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_WAIT;
            pc_d    = RESET_PC;
         end
         ST_WAIT: begin
            // Any returning word retires the request a kill was waiting on.
            if (imem.imem_ready_i) begin
               kill_d = 1'b0;
            end
            if (accept) begin
               ir_d  = imem.imem_rdata_i;
               npc_d = pc_q + 32'd4;
               vld_d = 1'b1;
               pc_d  = pc_q + 32'd4;
               if (stall_i) begin
                  state_d = ST_HOLD;
               end
            end else if (!stall_i) begin
               vld_d = 1'b0;
               ir_d  = NOP_WORD;
            end
         end
         ST_HOLD: begin
            if (!stall_i) begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      // A redirect overrides everything above; an unanswered request must be
      // drained before the new target can be presented.
      if (redirect) begin
         pc_d    = dest & 32'hFFFF_FFFC;
         vld_d   = 1'b0;
         ir_d    = NOP_WORD;
         state_d = ST_WAIT;
         if ((state_q == ST_WAIT) && !imem.imem_ready_i) begin
            kill_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         ir_q    <= NOP_WORD;
         npc_q   <= RESET_PC;
         vld_q   <= 1'b0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         npc_q   <= npc_d;
         vld_q   <= vld_d;
         kill_q  <= kill_d;
      end
   end

   assign imem.imem_req_o  = (state_q == ST_WAIT) && !kill_q;
   assign imem.imem_addr_o = pc_q;
   assign ir_o             = ir_q;
   assign npc_o            = npc_q;
   assign ir_valid_o       = vld_q;

`ifdef FETCH_CTRL_PERF_EN
   fetch_perf_cnt u_perf_fetch (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (accept),
      .cnt_o (perf_fetch_o)
   );

   fetch_perf_cnt u_perf_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (state_q == ST_HOLD),
      .cnt_o (perf_stall_o)
   );

   fetch_perf_cnt u_perf_redirect (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (redirect),
      .cnt_o (perf_redirect_o)
   );
`endif

endmodule
